// File: rtl/axi_lite_pattern_pkg.sv
// axi_lite_pattern_pkg: FSM/pattern enums, response code and LFSR polynomials shared by the pattern master
package axi_lite_pattern_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_WAIT_B, ST_READ, ST_WAIT_R, ST_DONE} state_e;
  typedef enum logic [1:0] {PAT_INC, PAT_WALK, PAT_LFSR, PAT_INC_ALT} pat_e;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] LFSR_POLY_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_POLY_64 = 64'hD800_0000_0000_0000;
endpackage

// File: rtl/axi_lite_pattern_gen.sv
// axi_lite_pattern_gen: sequential test-pattern word generator (incrementing, walking-one, optional Galois LFSR)
//   clk_i/rst_ni : clock, async active-low reset (word resets to 0)
//   load_i       : load word 0 of the pattern from seed_i/mode_i (has priority over adv_i)
//   adv_i        : advance to the next pattern word
//   mode_i       : pattern select; PAT_LFSR only exists when AXI_PATTERN_LFSR_EN is defined
//   seed_i       : pattern seed
//   data_o       : current pattern word
module axi_lite_pattern_gen
  import axi_lite_pattern_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          adv_i,
  input  pat_e          mode_i,
  input  logic [DW-1:0] seed_i,
  output logic [DW-1:0] data_o
);
  logic [DW-1:0] data_q, data_d, step, nxt;
  // walking-one is a rotate so the bit position wraps modulo DW
  assign step = mode_i == PAT_WALK ? {data_q[DW-2:0], data_q[DW-1]} : data_q + DW'(1);
`ifdef AXI_PATTERN_LFSR_EN
  localparam logic [DW-1:0] POLY = DW == 64 ? DW'(LFSR_POLY_64) : DW'(LFSR_POLY_32);
  // right-shifting Galois form: taps are XORed in when the bit shifted out is 1
  assign nxt = mode_i == PAT_LFSR ? (data_q >> 1) ^ (data_q[0] ? POLY : '0) : step;
`else
  assign nxt = step;
`endif
  assign data_d = load_i ? (mode_i == PAT_WALK ? DW'(1) : seed_i) : adv_i ? nxt : data_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) data_q <= '0;
    else data_q <= data_d;
  assign data_o = data_q;
endmodule

// File: rtl/axi_lite_pattern_master.sv
// axi_lite_pattern_master: AXI4-Lite master that writes a pattern to N addresses, reads it back and counts errors
//   ACLK/ARESETN  : clock, async active-low reset
//   INIT_AXI_TXN  : rising edge starts a run (ignored while a run is in progress)
//   PATTERN_SEL   : 0 incrementing, 1 walking-one, 2 LFSR (incrementing unless AXI_PATTERN_LFSR_EN), 3 incrementing
//   SEED          : pattern seed, latched at start
//   TXN_DONE      : run complete (level), ERROR: sticky failure, ERR_COUNT: saturating error count
//   M_AXI_*       : AXI4-Lite master channels, one write and one read outstanding at most
module axi_lite_pattern_master
  import axi_lite_pattern_pkg::*;
#(
  parameter     C_M_TARGET_BASE_ADDR = 32'h4000_0000,
  parameter int C_M_ADDR_WIDTH       = 32,
  parameter int C_M_DATA_WIDTH       = 32,
  parameter int C_M_TRANSACTIONS_NUM = 4,
  parameter int C_M_ADDR_STRIDE      = C_M_DATA_WIDTH / 8
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        INIT_AXI_TXN,
  input  logic [1:0]                  PATTERN_SEL,
  input  logic [C_M_DATA_WIDTH-1:0]   SEED,
  output logic                        TXN_DONE,
  output logic                        ERROR,
  output logic [8:0]                  ERR_COUNT,
  output logic [C_M_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_M_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [C_M_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_M_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);
  localparam int AW = C_M_ADDR_WIDTH;
  localparam int DW = C_M_DATA_WIDTH;
  localparam logic [AW-1:0] BASE     = AW'(C_M_TARGET_BASE_ADDR);
  localparam logic [AW-1:0] STRIDE   = AW'(C_M_ADDR_STRIDE);
  localparam logic [7:0]    LAST_IDX = 8'(C_M_TRANSACTIONS_NUM - 1);
  state_e        state_q, state_d;
  pat_e          mode_q, mode_d;
  logic          init_q, aw_q, aw_d, w_q, w_d, ar_q, ar_d, error_q, error_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] seed_q, seed_d, pat_word;
  logic [8:0]    err_cnt_q, err_cnt_d;
  logic          start, last, b_hs, r_hs, wr_go, rd_go, err_ev;
  assign start  = INIT_AXI_TXN & ~init_q & (state_q == ST_IDLE | state_q == ST_DONE);
  assign last   = cnt_q == LAST_IDX;
  assign b_hs   = state_q == ST_WAIT_B & M_AXI_BVALID;
  assign r_hs   = state_q == ST_WAIT_R & M_AXI_RVALID;
  assign wr_go  = start | (b_hs & ~last);
  assign rd_go  = (b_hs & last) | (r_hs & ~last);
  // a bad-data beat that also has a bad RRESP is still a single event
  assign err_ev = (b_hs & M_AXI_BRESP != RESP_OKAY) |
                  (r_hs & (M_AXI_RRESP != RESP_OKAY | M_AXI_RDATA != pat_word));
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_WRITE;
      ST_WRITE:  if ((~aw_q | M_AXI_AWREADY) & (~w_q | M_AXI_WREADY)) state_d = ST_WAIT_B;
      ST_WAIT_B: if (M_AXI_BVALID) state_d = last ? ST_READ : ST_WRITE;
      ST_READ:   if (ar_q & M_AXI_ARREADY) state_d = ST_WAIT_R;
      ST_WAIT_R: if (M_AXI_RVALID) state_d = last ? ST_DONE : ST_READ;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    M_AXI_BREADY = state_q == ST_WAIT_B;
    M_AXI_RREADY = state_q == ST_WAIT_R;
    TXN_DONE     = state_q == ST_DONE;
  end
  // each VALID is set on entry to its phase and drops independently after its own handshake
  always_comb begin
    aw_d      = wr_go | (aw_q & ~M_AXI_AWREADY);
    w_d       = wr_go | (w_q & ~M_AXI_WREADY);
    ar_d      = rd_go | (ar_q & ~M_AXI_ARREADY);
    addr_d    = start | (b_hs & last) ? BASE : b_hs | r_hs ? addr_q + STRIDE : addr_q;
    cnt_d     = start | (b_hs & last) ? '0 : b_hs | r_hs ? cnt_q + 8'd1 : cnt_q;
    seed_d    = start ? SEED : seed_q;
    mode_d    = start ? pat_e'(PATTERN_SEL) : mode_q;
    error_d   = ~start & (error_q | err_ev);
    err_cnt_d = start ? '0 : err_ev & ~&err_cnt_q ? err_cnt_q + 9'd1 : err_cnt_q;
  end
  // init_q resets high so an INIT held through reset release is not seen as an edge
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      init_q    <= 1'b1;
      aw_q      <= 1'b0;
      w_q       <= 1'b0;
      ar_q      <= 1'b0;
      addr_q    <= BASE;
      cnt_q     <= '0;
      seed_q    <= '0;
      mode_q    <= PAT_INC;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      init_q    <= INIT_AXI_TXN;
      aw_q      <= aw_d;
      w_q       <= w_d;
      ar_q      <= ar_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      mode_q    <= mode_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  // loaded at start for the write phase and again after the last B to replay the pattern for reads
  axi_lite_pattern_gen #(.DW(DW)) u_gen (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .load_i (start | (b_hs & last)),
    .adv_i  ((b_hs & ~last) | r_hs),
    .mode_i (start ? pat_e'(PATTERN_SEL) : mode_q),
    .seed_i (start ? SEED : seed_q),
    .data_o (pat_word)
  );
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WDATA   = pat_word;
  assign M_AXI_AWVALID = aw_q;
  assign M_AXI_WVALID  = w_q;
  assign M_AXI_ARVALID = ar_q;
  assign ERROR         = error_q;
  assign ERR_COUNT     = err_cnt_q;
endmodule

// File: tb/tb_axi_lite_pattern_master.sv
// tb_axi_lite_pattern_master: directed + randomized runs against a memory slave and a pattern reference model
module tb_axi_lite_pattern_master;
  import axi_lite_pattern_pkg::*;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk = 1'b0, rstn = 1'b0, init = 1'b0, clr = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [31:0] seed = '0;
  logic done, error;
  logic [8:0] err_cnt;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  int checks = 0, failures = 0;
  int aw_dly = 0, w_dly = 0, bad_b = -1, bad_r = -1, cor_r = -1;
  logic [31:0] cor_val = 32'hDEAD0011;
  logic [31:0] mem [logic [31:0]];
  int wcnt [logic [31:0]];
  int aw_cnt, w_cnt;
  logic have_aw, have_w, w_first, aw_hs, w_hs;
  logic [31:0] aw_l, w_l, wa, wd;

  always #5 clk = ~clk;

  axi_lite_pattern_master dut (
    .ACLK(clk), .ARESETN(rstn), .INIT_AXI_TXN(init), .PATTERN_SEL(sel), .SEED(seed),
    .TXN_DONE(done), .ERROR(error), .ERR_COUNT(err_cnt),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // memory slave: ready after a programmable number of valid cycles, response one cycle after capture
  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = 1'b1;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign wa      = aw_hs ? awaddr : aw_l;
  assign wd      = w_hs ? wdata : w_l;

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; have_aw <= 1'b0; have_w <= 1'b0; w_first <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (clr) begin
        mem.delete();
        wcnt.delete();
        w_first <= 1'b0;
      end else if (awvalid && !wvalid) w_first <= 1'b1;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (aw_hs) begin aw_l <= awaddr; have_aw <= 1'b1; end
      if (w_hs) begin w_l <= wdata; have_w <= 1'b1; end
      if (bvalid && bready) bvalid <= 1'b0;
      if ((have_aw || aw_hs) && (have_w || w_hs)) begin
        mem[wa] = wd;
        wcnt[wa] = (wcnt.exists(wa) ? wcnt[wa] : 0) + 1;
        have_aw <= 1'b0;
        have_w <= 1'b0;
        bvalid <= 1'b1;
        bresp <= (idx(wa) == bad_b) ? 2'b10 : 2'b00;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata <= (idx(araddr) == cor_r) ? cor_val : (mem.exists(araddr) ? mem[araddr] : 32'h0);
        rresp <= (idx(araddr) == bad_r) ? 2'b10 : 2'b00;
      end
    end

  // word i of a pattern, straight from the pattern definitions
  function automatic logic [31:0] model_word(input logic [1:0] p, input logic [31:0] s, input int i);
    logic [31:0] v;
    bit lfsr_on;
    lfsr_on = 1'b0;
`ifdef AXI_PATTERN_LFSR_EN
    lfsr_on = 1'b1;
`endif
    if (p == 2'd1) return 32'h1 << (i % 32);
    if (p == 2'd2 && lfsr_on) begin
      v = s;
      for (int k = 0; k < i; k++) v = v[0] ? (v >> 1) ^ LFSR_POLY_32 : v >> 1;
      return v;
    end
    return s + 32'(i);
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one full run; lat counts cycles from the edge-detect cycle until TXN_DONE is seen, -1 on timeout
  task automatic run(input logic [1:0] p, input logic [31:0] s, input bit poke, output int lat);
    init = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sel = p;
    seed = s;
    init = 1'b1;
    lat = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (poke && c == 3) init = 1'b0;
      if (poke && c == 5) init = 1'b1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic verify(input string tag, input logic [1:0] p, input logic [31:0] s, input int exp_err);
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = BASE + 32'(i * 4);
      chk({tag, "_data"}, rd(a), model_word(p, s, i));
      chk({tag, "_wcnt"}, wcnt.exists(a) ? wcnt[a] : 0, 1);
    end
    chk({tag, "_errcnt"}, err_cnt, exp_err);
    chk({tag, "_error"}, error, exp_err != 0);
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    int lat;
    logic [1:0] p;
    logic [31:0] s;
    bit any;
    repeat (3) @(negedge clk);
    chk("rst_valid_ready", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_status", {done, error, err_cnt}, 0);
    chk("rst_awaddr", awaddr, BASE);
    chk("rst_araddr", araddr, BASE);
    chk("rst_wdata", wdata, 0);
    chk("prot_strb", {awprot, arprot, wstrb}, 10'h00F);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run(2'd0, 32'h0101FFFF, 1'b0, lat);
    chk("basic_latency", lat, 17);
    chk("basic_word3", rd(BASE + 32'hC), 32'h01020002);
    verify("basic", 2'd0, 32'h0101FFFF, 0);

    for (int k = 0; k < 6; k++) begin
      p = 2'($urandom_range(0, 3));
      s = $urandom;
      aw_dly = (k >= 3) ? $urandom_range(0, 3) : 0;
      w_dly = (k >= 3) ? $urandom_range(0, 3) : 0;
      run(p, s, 1'b0, lat);
      if (aw_dly == 0 && w_dly == 0) chk("rand_latency", lat, 17);
      else chk("rand_completes", lat != -1, 1);
      verify("rand", p, s, 0);
    end

    aw_dly = 3;
    w_dly = 0;
    run(2'd0, 32'h1234_0000, 1'b0, lat);
    chk("wfirst_wvalid_dropped_first", w_first, 1);
    chk("wfirst_latency", lat, 4 * 4 + 1 + 4 * 3);
    verify("wfirst", 2'd0, 32'h1234_0000, 0);
    aw_dly = 0;

    cor_r = 2;
    run(2'd1, 32'h0, 1'b0, lat);
    chk("corrupt_latency", lat, 17);
    verify("corrupt", 2'd1, 32'h0, 1);
    cor_r = -1;

    bad_b = 0;
    bad_r = 3;
    cor_r = 3;
    run(2'd0, 32'h100, 1'b0, lat);
    verify("badresp", 2'd0, 32'h100, 2);
    bad_b = -1;
    bad_r = -1;
    cor_r = -1;

    run(2'd2, 32'h1, 1'b0, lat);
`ifdef AXI_PATTERN_LFSR_EN
    chk("lfsr_word1", rd(BASE + 32'h4), 32'h8020_0003);
`else
    chk("lfsr_word1", rd(BASE + 32'h4), 32'h0000_0002);
`endif
    verify("lfsr", 2'd2, 32'h1, 0);

    s = $urandom;
    run(2'd0, s, 1'b1, lat);
    chk("busy_edge_latency", lat, 17);
    verify("busy_edge", 2'd0, s, 0);

    init = 1'b0;
    @(negedge clk);
    seed = $urandom;
    init = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rready) break;
    end
    chk("rst_mid_in_wait_r", rready, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_async", {awvalid, wvalid, arvalid, bready, rready, done}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any = any | awvalid | wvalid | arvalid | done;
    end
    chk("rst_mid_no_start", any, 0);
    s = $urandom;
    run(2'd0, s, 1'b0, lat);
    chk("rst_mid_restart_latency", lat, 17);
    verify("rst_mid_restart", 2'd0, s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
